// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: FSM state encoding and default timing constants shared by the stopwatch control files
package stopwatch_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } sw_state_t;
    localparam int TICK_DIV_DEFAULT   = 100_000_000;
    localparam int DEB_CYCLES_DEFAULT = 1_000_000;
endpackage

// File: rtl/stopwatch_btn_conditioner.sv
// btn_conditioner: 2-flop sync + debounce (DEB_CYCLES stable samples) + registered rise pulse; clk, rst in; btn_raw async in; press 1-cycle out
module btn_conditioner
    import stopwatch_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q, level_prev_q, press_q;
    logic          differ, done;
    assign differ = sync_q[1] != level_q;
    assign done   = cnt_q == CW'(DEB_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], btn_raw};
            cnt_q        <= (differ && !done) ? cnt_q + CW'(1) : '0;
            level_q      <= (differ && done) ? sync_q[1] : level_q;
            level_prev_q <= level_q;
            press_q      <= level_q & ~level_prev_q;
        end
    end
    assign press = press_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: IDLE/RUN/PAUSE FSM + tick prescaler; in clk rst btn_ss btn_rst [btn_lap]; out tick clr running state [hold]; SPLIT_EN adds lap/hold
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEFAULT,
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_rst,
`ifdef SPLIT_EN
    input  logic       btn_lap,
    output logic       hold,
`endif
    output logic       tick,
    output logic       clr,
    output logic       running,
    output logic [1:0] state
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
    sw_state_t     state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          ss_press, rst_press;
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_ss (
        .clk(clk), .rst(rst), .btn_raw(btn_ss), .press(ss_press)
    );
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_rst (
        .clk(clk), .rst(rst), .btn_raw(btn_rst), .press(rst_press)
    );
    always_comb begin
        state_d = IDLE;
        presc_d = '0;
        if (!rst_press) begin
            case (state_q)
                IDLE:  state_d = ss_press ? RUN : IDLE;
                RUN: begin
                    state_d = ss_press ? PAUSE : RUN;
                    presc_d = (presc_q == LAST) ? '0 : presc_q + PW'(1);
                end
                PAUSE: begin
                    state_d = ss_press ? RUN : PAUSE;
                    presc_d = presc_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
        end
    end
    assign running = state_q == RUN;
    assign tick    = running && presc_q == LAST && !rst_press;
    assign clr     = rst_press;
    assign state   = state_q;
`ifdef SPLIT_EN
    logic lap_press, hold_q, hold_d;
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_lap (
        .clk(clk), .rst(rst), .btn_raw(btn_lap), .press(lap_press)
    );
    // toggles only while staying in RUN; any exit or reset press forces it low
    assign hold_d = state_q == RUN && state_d == RUN && (hold_q ^ lap_press);
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
        end
    end
    assign hold = hold_q;
`endif
endmodule
